mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin controller that shares the 32-bit 4:1 selection datapath among four requesters. It arbitrates among four request lines and drives the 2-bit select (`sel1`, `sel2`) of the 4:1 mux. It presents the selected word downstream with a valid/ready handshake. It holds a grant for a burst and optionally limits burst length to enforce fairness.

## Interface
- `WIDTH`, 32: data width of each input word and of `out`.
- `MAX_BURST`, 4: maximum beats per grant when the burst limit is compiled in; legal range 1..16.

- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  4  request per requester; bit i = requester i.
- `in1`, `in2`, `in3`, `in4`  input  WIDTH each  data words for requesters 0..3.
- `out_ready`  input  1  downstream accepts `out` this cycle.
- `gnt`  output  4  one-hot grant, registered; 0000 when idle.
- `sel1`, `sel2`  output  1 each  registered mux select (encoding below).
- `out`  output  WIDTH  selected word = mux(in1..in4) under the current `sel1`/`sel2`.
- `out_valid`  output  1  `out` carries a beat this cycle.
- `busy`  output  1  high while in GRANT.

## Operation
- Select encoding: owner 0 → sel1=0, sel2=0 (`in1`); owner 1 → sel1=1, sel2=0 (`in2`); owner 2 → sel1=0, sel2=1 (`in3`); owner 3 → sel1=1, sel2=1 (`in4`).
- FSM has two states, IDLE and GRANT.
- **IDLE:**
  - If `req` is 0000, stay in IDLE.
  - Otherwise pick the first set bit scanning from `last+1` upward, modulo 4.
  - Register `gnt`, `sel1`/`sel2` and `owner`, clear the beat count, and go to GRANT.
- **GRANT:**
  - `out_valid = req[owner]`.
  - Transfer = `out_valid & out_ready`.
  - The requester sees its beat consumed when `gnt[i] & out_ready`. It must hold `req` and its data stable until the transfer.
- **Release:** leave GRANT for IDLE when either condition holds:
  - `req[owner]` is sampled low, or
  - the burst limit is hit (see Configuration).
- On release:
  - `last` ← `owner`.
  - `gnt` ← 0000.
  - `sel1`/`sel2` hold their last value.
- If requester i drops `req` while `out_valid & !out_ready`, the beat is abandoned. `out_valid` falls in the same cycle (combinational from `req`) and the grant releases.
- Beat count: 4-bit. It increments on each transfer, saturates at `MAX_BURST`, and is cleared on entering GRANT.
- `out` is purely combinational from the registered selects. It is meaningful only when `out_valid`=1.
- **Reset values:**
  - state = IDLE, `gnt` = 0000, `sel1` = `sel2` = 0, `out_valid` = 0, `busy` = 0.
  - `last` = 3, so requester 0 has top priority first.
  - Beat count = 0.

## Timing
- Grant latency: `req` sampled in IDLE at edge N → `gnt`, `sel1`/`sel2`, `busy` valid after edge N (the cycle following N). `out_valid` can go high in that cycle.
- One beat per cycle while `out_ready`=1 and `req[owner]`=1.
- Release costs one IDLE cycle. The next grant appears two cycles after the last beat of the previous owner, so there is one bubble between owners.
- Simultaneous requests in IDLE are resolved solely by the round-robin pointer. A new request arriving during GRANT waits for release.
- `out_ready` low: no transfer, count unchanged, grant held indefinitely.
- `reset` asserted mid-burst: all outputs take reset values after that edge. The pending beat is dropped and `last` returns to 3.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - A transfer that brings the beat count to `MAX_BURST` forces release at that edge, even if `req[owner]` stays high.
  - The owner re-competes in IDLE at lowest priority.
- `ARB_BURST_LIMIT_EN` undefined:
  - No beat counter is built.
  - The grant is held until `req[owner]` drops; a continuous requester can starve the others.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `sel1`=`sel2`=0, `out_valid`=0, `busy`=0. First grant after reset release is requester 0.
- **Single request:** `req`=0100, `in3`=0x0000_1240, `out_ready`=1 → `gnt`=0100 one cycle later, sel1=0, sel2=1, `out`=0x0000_1240, `out_valid`=1. Drop `req` → `gnt`=0000 next cycle.
- **Fair rotation** (`ARB_BURST_LIMIT_EN`, `MAX_BURST`=4): `req`=1111 held, `out_ready`=1 → grants 0,1,2,3,0. Each owner gets exactly 4 beats with one idle cycle between owners.
- **Backpressure:** owner 1 granted, `out_ready`=0 for 3 cycles → `out_valid`=1, `gnt`=0010 stable, beat count frozen. Burst completes 4 transfers after `out_ready` returns.
- **Reset mid-burst:** owner 2 after 2 beats, assert `reset` → next cycle `gnt`=0000, `sel1`=`sel2`=0. With `req`=0101 after reset, the grant goes to requester 0.
- **No limit** (macro undefined): `req[0]` held 10 cycles with `req[1]`=1 → `gnt`=0001 all 10 cycles. Drop `req[0]` → `gnt`=0010 two cycles later.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4:1 WIDTH-bit mux, optional burst cap under `ARB_BURST_LIMIT_EN.
// Latency: gnt/sel1/sel2/busy registered one cycle after req is sampled in IDLE; out/out_valid combinational.
// Backpressure: out_ready low freezes the burst and holds the grant; one idle bubble between owners.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic             sel1,
    output logic             sel2,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] last;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       limit_hit;

    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
        $error("mux4_rr_arbiter: MAX_BURST must be 1..16");
    end

    // Scan starts just past the previous owner, so it ends up lowest priority.
    always_comb begin
        pick  = last;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign out_valid = busy & req[owner];

    always_comb begin
        case ({sel2, sel1})
            2'b00:   out = in1;
            2'b01:   out = in2;
            2'b10:   out = in3;
            default: out = in4;
        endcase
    end

`ifdef ARB_BURST_LIMIT_EN
    logic [3:0] beats;
    logic       xfer;

    assign xfer      = out_valid & out_ready;
    assign limit_hit = xfer && (({1'b0, beats} + 5'd1) >= 5'(MAX_BURST));
`else
    logic unused_rdy;

    // Without the cap the grant only ends when the owner drops req.
    assign unused_rdy = out_ready;
    assign limit_hit  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel1  <= 1'b0;
            sel2  <= 1'b0;
            busy  <= 1'b0;
            owner <= 2'd0;
            last  <= 2'd3;
`ifdef ARB_BURST_LIMIT_EN
            beats <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        busy  <= 1'b1;
                        owner <= pick;
                        gnt   <= 4'b0001 << pick;
                        sel1  <= pick[0];
                        sel2  <= pick[1];
`ifdef ARB_BURST_LIMIT_EN
                        beats <= 4'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[owner] || limit_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        gnt   <= 4'b0000;
                        last  <= owner;
                    end
`ifdef ARB_BURST_LIMIT_EN
                    if (xfer && ({1'b0, beats} < 5'(MAX_BURST)))
                        beats <= beats + 4'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; covers both burst-limit build options.
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [WIDTH-1:0] in1, in2, in3, in4;
    logic             out_ready;
    logic [3:0]       gnt;
    logic             sel1, sel2;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .out_ready(out_ready), .gnt(gnt), .sel1(sel1), .sel2(sel2),
        .out(out), .out_valid(out_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_arb(input string tag, input logic [3:0] eg, input logic [1:0] esel,
                             input logic ebusy);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".sel"}, 32'({sel2, sel1}), 32'(esel));
        check({tag, ".busy"}, 32'(busy), 32'(ebusy));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = 4'b1111; out_ready = 1'b0;
        in1 = 32'hA1A1_0001; in2 = 32'hB2B2_0002; in3 = 32'h0000_1240; in4 = 32'hD4D4_0004;
        tick; tick;
        check_arb("rst", 4'b0000, 2'b00, 1'b0);
        check("rst.ov", 32'(out_valid), 32'd0);

        // first grant after reset goes to requester 0
        reset = 1'b0;
        tick;
        check_arb("first", 4'b0001, 2'b00, 1'b1);
        check("first.ov", 32'(out_valid), 32'd1);
        check("first.out", out, 32'hA1A1_0001);
        req = 4'b0000;
        #1;
        check("abandon.ov", 32'(out_valid), 32'd0);
        tick;
        check_arb("rel0", 4'b0000, 2'b00, 1'b0);

        // single request on requester 2
        req = 4'b0100; out_ready = 1'b1;
        tick;
        check_arb("single", 4'b0100, 2'b10, 1'b1);
        check("single.out", out, 32'h0000_1240);
        check("single.ov", 32'(out_valid), 32'd1);
        req = 4'b0000;
        tick;
        check_arb("single.rel", 4'b0000, 2'b10, 1'b0);

        // all requesting, pointer at 2 -> owner 3
        req = 4'b1111;
        tick;
        check_arb("own3", 4'b1000, 2'b11, 1'b1);
        check("own3.out", out, 32'hD4D4_0004);
`ifdef ARB_BURST_LIMIT_EN
        for (int o = 0; o < 4; o++) begin
            logic [1:0] cur;
            logic [1:0] nxt;
            cur = 2'(3 + o);
            nxt = cur + 2'd1;
            for (int b = 0; b < 3; b++) begin
                tick;
                check_arb("rot.hold", 4'b0001 << cur, {cur[1], cur[0]}, 1'b1);
            end
            tick;
            check_arb("rot.bubble", 4'b0000, {cur[1], cur[0]}, 1'b0);
            tick;
            check_arb("rot.next", 4'b0001 << nxt, {nxt[1], nxt[0]}, 1'b1);
        end
`else
        for (int b = 0; b < 6; b++) begin
            tick;
            check_arb("hold3", 4'b1000, 2'b11, 1'b1);
        end
`endif
        req = 4'b0111;
        #1;
        check("drop3.ov", 32'(out_valid), 32'd0);
        tick;
        check_arb("drop3.rel", 4'b0000, 2'b11, 1'b0);
        tick;
        check_arb("own0", 4'b0001, 2'b00, 1'b1);

        // backpressure on owner 1
        req = 4'b0010;
        tick;
        check_arb("bp.rel0", 4'b0000, 2'b00, 1'b0);
        tick;
        check_arb("bp.own1", 4'b0010, 2'b01, 1'b1);
        check("bp.out", out, 32'hB2B2_0002);
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick;
            check_arb("bp.stall", 4'b0010, 2'b01, 1'b1);
            check("bp.stall.ov", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick;
            check_arb("bp.beat", 4'b0010, 2'b01, 1'b1);
        end
        tick;
`ifdef ARB_BURST_LIMIT_EN
        check_arb("bp.limit", 4'b0000, 2'b01, 1'b0);
        req = 4'b0000;
`else
        check_arb("bp.nolimit", 4'b0010, 2'b01, 1'b1);
        req = 4'b0000;
        tick;
        check_arb("bp.rel", 4'b0000, 2'b01, 1'b0);
`endif

        // reset in the middle of owner 2's burst
        req = 4'b0100;
        tick;
        check_arb("mid.own2", 4'b0100, 2'b10, 1'b1);
        tick; tick;
        reset = 1'b1; req = 4'b0101;
        tick;
        check_arb("mid.rst", 4'b0000, 2'b00, 1'b0);
        check("mid.rst.ov", 32'(out_valid), 32'd0);
        reset = 1'b0;
        tick;
        check_arb("mid.own0", 4'b0001, 2'b00, 1'b1);

        // owner 0 keeps requesting while requester 1 waits
        req = 4'b0011;
`ifdef ARB_BURST_LIMIT_EN
        for (int b = 0; b < 3; b++) begin
            tick;
            check_arb("cap.hold", 4'b0001, 2'b00, 1'b1);
        end
        tick;
        check_arb("cap.rel", 4'b0000, 2'b00, 1'b0);
`else
        for (int b = 0; b < 10; b++) begin
            tick;
            check_arb("starve.hold", 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b0010;
        tick;
        check_arb("starve.rel", 4'b0000, 2'b00, 1'b0);
`endif
        tick;
        check_arb("own1", 4'b0010, 2'b01, 1'b1);
        in2 = 32'h5A5A_C3C3;
        #1;
        check("own1.out", out, 32'h5A5A_C3C3);
        check("own1.ov", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
